bp_update_arbiter: RTL and testbench
====================================

# bp_update_arbiter

Arbiter and sequencer for the single shared access port of the direction-predictor tables (bimodal, global, choice PHTs). It queues branch-resolution updates from EX, arbitrates the table port between front-end prediction reads and queued updates, and prevents update starvation. After reset or a flush, it runs a clear walk that initialises every table entry.

## Interface
Parameters:
- gh_width, 14, width of global-history hashed index
- bh_width, 14, width of bimodal hashed index
- ADDR_WIDTH, 30, PC width
- FIFO_DEPTH, 4, update queue entries (power of 2, ≥2)
- STARVE_LIM, 8, max cycles head entry may be denied before it is forced

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- flush_tables  in  1  request full table re-initialisation
- ex_valid  in  1  EX presents a resolved branch
- ex_ready  out  1  queue can accept
- pc_ex  in  ADDR_WIDTH  branch PC
- pc_ex_gh_hashed  in  gh_width  global index
- pc_ex_bh_hashed  in  bh_width  bimodal index
- kind_ex  in  3  branch kind (1 = DIRECT_JUMP)
- taken_real, choice_real  in  1 each  resolved outcome / correct chooser
- taken_pdch_ex_b, taken_pdch_ex_g, choice_pdch_ex  in  2 each  counters read at prediction
- pdc_req  in  1  front end requests the table port for a prediction read
- pdc_grant  out  1  prediction read granted this cycle
- upd_en  out  1  table write this cycle
- upd_clear  out  1  write is an init write (counters forced to 2'b01)
- upd_gh_idx  out  gh_width, upd_bh_idx  out  bh_width  write indices
- upd_taken, upd_choice  out  1 each
- upd_pdch_b, upd_pdch_g, upd_pdch_c  out  2 each
- clearing  out  1  clear walk in progress

## Operation
- States: CLEAR and RUN. rst forces CLEAR with idx=0, FIFO empty, and age=0.
- CLEAR: each cycle upd_en=1, upd_clear=1, upd_gh_idx=idx[gh_width-1:0], upd_bh_idx=idx[bh_width-1:0], upd_taken=upd_choice=0, pdch outputs=2'b01. idx width IW=max(gh_width,bh_width). The state exits to RUN after the cycle with idx=2^IW-1. In CLEAR, ex_ready=0 and pdc_grant=0.
- RUN: ex_ready=(count<FIFO_DEPTH). A handshake is ex_valid&&ex_ready. Only kind_ex==1 is enqueued. Other kinds complete the handshake and are dropped.
- Head fields drive the upd_* outputs combinationally. upd_clear=0.
- force=(count==FIFO_DEPTH)||(age>=STARVE_LIM).
- An update wins when the FIFO is non-empty and (!pdc_req||force). Then upd_en=1, the head is popped, and age is reset to 0.
- pdc_grant=pdc_req&&!update_wins.
- age increments, saturating at STARVE_LIM, in each cycle the FIFO is non-empty and the update loses. Otherwise age=0.
- Push and pop in the same cycle are both performed, and count is unchanged.
- flush_tables in either state: the FIFO is emptied, age=0, idx=0, and the next state is CLEAR. Any push that cycle is discarded. A flush during CLEAR restarts the walk.
- Pointers wrap modulo FIFO_DEPTH.

## Timing
- Reset values: upd_en=0, upd_clear=0, clearing=1, ex_ready=0, pdc_grant=0, and all index/data outputs 0 during the rst cycle.
- The first clear write occurs in the first cycle after rst deasserts. The walk lasts exactly 2^IW cycles. RUN begins in the next cycle (clearing=0).
- Enqueue latency: an entry accepted at edge k into an empty FIFO drives upd_en in cycle k+1 if it wins. It is popped at edge k+1.
- Throughput is one update per cycle.
- Worst-case wait for a pdc_req-contended head is STARVE_LIM+1 cycles.
- ex_ready depends only on registered count and state. It has no combinational path from ex_valid or pdc_req.

## Test plan
- Reset with gh_width=bh_width=4, then release: 16 consecutive cycles show upd_en=1, upd_clear=1, idx 0..15, and pdch=2'b01. Then clearing=0 and ex_ready=1.
- RUN, pdc_req=0, one DIRECT_JUMP push with gh idx 0x5 and taken=1: the next cycle shows upd_en=1, upd_gh_idx=0x5, upd_taken=1, and the FIFO is empty afterwards.
- pdc_req held at 1 with one queued entry: pdc_grant=1 for 8 cycles. In the 9th cycle upd_en=1 and pdc_grant=0. Then pdc_grant returns to 1.
- pdc_req=1 with 4 pushes: count reaches 4 and ex_ready=0. In the next cycle force gives upd_en=1 and pdc_grant=0. ex_ready=1 the cycle after.
- Pushes with kind_ex=0,2,4: the handshake completes and upd_en never asserts.
- flush_tables with 3 queued entries: the next cycle is CLEAR at idx 0 and the old entries are never written.
- rst asserted mid-walk at idx 7: the walk restarts at idx 0.

Source files
------------

// File: rtl/bp_update_arbiter.sv
// bp_update_arbiter
// Sequences the single shared port of the direction-predictor tables (bimodal,
// global, choice PHTs). Resolved DIRECT_JUMP branches from EX are queued and
// written back when the front end is not reading, or when the queue head has
// been starved or the queue is full. After reset or flush_tables a clear walk
// writes every table index with counters = 2'b01.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   flush_tables             restart the clear walk and drop queued updates
//   ex_valid / ex_ready      EX update handshake
//   pc_ex, pc_ex_*_hashed    branch PC and hashed table indices
//   kind_ex                  branch kind, only 3'd1 (DIRECT_JUMP) is queued
//   taken_real, choice_real  resolved outcome and correct chooser
//   taken_pdch_ex_b/_g, choice_pdch_ex  counters read at prediction time
//   pdc_req / pdc_grant      front-end prediction read request / grant
//   upd_*                    table write port
//   clearing                 clear walk in progress
module bp_update_arbiter #(
  parameter int unsigned gh_width   = 14,
  parameter int unsigned bh_width   = 14,
  parameter int unsigned ADDR_WIDTH = 30,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned STARVE_LIM = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_tables,
  input  logic                  ex_valid,
  output logic                  ex_ready,
  input  logic [ADDR_WIDTH-1:0] pc_ex,
  input  logic [gh_width-1:0]   pc_ex_gh_hashed,
  input  logic [bh_width-1:0]   pc_ex_bh_hashed,
  input  logic [2:0]            kind_ex,
  input  logic                  taken_real,
  input  logic                  choice_real,
  input  logic [1:0]            taken_pdch_ex_b,
  input  logic [1:0]            taken_pdch_ex_g,
  input  logic [1:0]            choice_pdch_ex,
  input  logic                  pdc_req,
  output logic                  pdc_grant,
  output logic                  upd_en,
  output logic                  upd_clear,
  output logic [gh_width-1:0]   upd_gh_idx,
  output logic [bh_width-1:0]   upd_bh_idx,
  output logic                  upd_taken,
  output logic                  upd_choice,
  output logic [1:0]            upd_pdch_b,
  output logic [1:0]            upd_pdch_g,
  output logic [1:0]            upd_pdch_c,
  output logic                  clearing
);

  localparam int unsigned IW = (gh_width > bh_width) ? gh_width : bh_width;
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned AW = $clog2(STARVE_LIM + 1);

  localparam logic [CW-1:0] FullCount = CW'(FIFO_DEPTH);
  localparam logic [AW-1:0] AgeLim    = AW'(STARVE_LIM);
  localparam logic [IW-1:0] IdxLast   = {IW{1'b1}};

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  logic [0:0]    r_state;
  logic [IW-1:0] r_idx;
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [AW-1:0] r_age;

  logic [gh_width-1:0] r_gh_mem  [FIFO_DEPTH];
  logic [bh_width-1:0] r_bh_mem  [FIFO_DEPTH];
  logic                r_tk_mem  [FIFO_DEPTH];
  logic                r_ch_mem  [FIFO_DEPTH];
  logic [1:0]          r_pb_mem  [FIFO_DEPTH];
  logic [1:0]          r_pg_mem  [FIFO_DEPTH];
  logic [1:0]          r_pc_mem  [FIFO_DEPTH];

  logic w_run, w_empty, w_ex_ready, w_force, w_upd_win, w_push, w_pop;
  logic w_unused_pc;

  // The PC travels with the update for debug only; the tables are indexed by hashes.
  assign w_unused_pc = ^pc_ex;

  assign w_run      = (r_state == ST_RUN);
  assign w_empty    = (r_count == '0);
  assign w_ex_ready = w_run && (r_count < FullCount);
  assign w_force    = (r_count == FullCount) || (r_age >= AgeLim);
  // A flush cycle never writes a queued entry: the queue is being discarded.
  assign w_upd_win  = !rst && w_run && !flush_tables && !w_empty && (!pdc_req || w_force);
  assign w_pop      = w_upd_win;
  // Non-DIRECT_JUMP kinds still complete the handshake but are not stored.
  assign w_push     = w_run && !flush_tables && ex_valid && w_ex_ready && (kind_ex == 3'd1);

  always_ff @(posedge clk) begin
    if (rst || flush_tables) begin
      r_state  <= ST_CLEAR;
      r_idx    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_age    <= '0;
    end else if (!w_run) begin
      r_idx <= r_idx + 1'b1;
      if (r_idx == IdxLast) r_state <= ST_RUN;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
      // Age counts cycles the head has been denied; it saturates so force stays set.
      if (!w_empty && !w_upd_win) r_age <= (r_age == AgeLim) ? AgeLim : r_age + 1'b1;
      else                        r_age <= '0;
    end
  end

  // Queue storage needs no reset: only entries below r_count are ever observed.
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_gh_mem[r_wr_ptr] <= pc_ex_gh_hashed;
      r_bh_mem[r_wr_ptr] <= pc_ex_bh_hashed;
      r_tk_mem[r_wr_ptr] <= taken_real;
      r_ch_mem[r_wr_ptr] <= choice_real;
      r_pb_mem[r_wr_ptr] <= taken_pdch_ex_b;
      r_pg_mem[r_wr_ptr] <= taken_pdch_ex_g;
      r_pc_mem[r_wr_ptr] <= choice_pdch_ex;
    end
  end

  always_comb begin
    upd_en     = 1'b0;
    upd_clear  = 1'b0;
    upd_gh_idx = '0;
    upd_bh_idx = '0;
    upd_taken  = 1'b0;
    upd_choice = 1'b0;
    upd_pdch_b = 2'b00;
    upd_pdch_g = 2'b00;
    upd_pdch_c = 2'b00;
    if (!rst) begin
      if (!w_run) begin
        upd_en     = 1'b1;
        upd_clear  = 1'b1;
        upd_gh_idx = r_idx[gh_width-1:0];
        upd_bh_idx = r_idx[bh_width-1:0];
        upd_pdch_b = 2'b01;
        upd_pdch_g = 2'b01;
        upd_pdch_c = 2'b01;
      end else begin
        upd_en     = w_upd_win;
        upd_gh_idx = r_gh_mem[r_rd_ptr];
        upd_bh_idx = r_bh_mem[r_rd_ptr];
        upd_taken  = r_tk_mem[r_rd_ptr];
        upd_choice = r_ch_mem[r_rd_ptr];
        upd_pdch_b = r_pb_mem[r_rd_ptr];
        upd_pdch_g = r_pg_mem[r_rd_ptr];
        upd_pdch_c = r_pc_mem[r_rd_ptr];
      end
    end
  end

  assign ex_ready  = !rst && w_ex_ready;
  assign pdc_grant = !rst && w_run && pdc_req && !w_upd_win;
  assign clearing  = rst || !w_run;

endmodule

// File: tb/tb_bp_update_arbiter.sv
// Directed self-checking bench for bp_update_arbiter with 4-bit indices
// (16-cycle clear walk), a 4-entry queue and a starvation limit of 8.
module tb_bp_update_arbiter;

  logic        clk = 1'b0;
  logic        rst, flush_tables, ex_valid, ex_ready;
  logic [29:0] pc_ex;
  logic [3:0]  pc_ex_gh_hashed, pc_ex_bh_hashed;
  logic [2:0]  kind_ex;
  logic        taken_real, choice_real;
  logic [1:0]  taken_pdch_ex_b, taken_pdch_ex_g, choice_pdch_ex;
  logic        pdc_req, pdc_grant, upd_en, upd_clear;
  logic [3:0]  upd_gh_idx, upd_bh_idx;
  logic        upd_taken, upd_choice;
  logic [1:0]  upd_pdch_b, upd_pdch_g, upd_pdch_c;
  logic        clearing;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  bp_update_arbiter #(
    .gh_width  (4),
    .bh_width  (4),
    .ADDR_WIDTH(30),
    .FIFO_DEPTH(4),
    .STARVE_LIM(8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .flush_tables   (flush_tables),
    .ex_valid       (ex_valid),
    .ex_ready       (ex_ready),
    .pc_ex          (pc_ex),
    .pc_ex_gh_hashed(pc_ex_gh_hashed),
    .pc_ex_bh_hashed(pc_ex_bh_hashed),
    .kind_ex        (kind_ex),
    .taken_real     (taken_real),
    .choice_real    (choice_real),
    .taken_pdch_ex_b(taken_pdch_ex_b),
    .taken_pdch_ex_g(taken_pdch_ex_g),
    .choice_pdch_ex (choice_pdch_ex),
    .pdc_req        (pdc_req),
    .pdc_grant      (pdc_grant),
    .upd_en         (upd_en),
    .upd_clear      (upd_clear),
    .upd_gh_idx     (upd_gh_idx),
    .upd_bh_idx     (upd_bh_idx),
    .upd_taken      (upd_taken),
    .upd_choice     (upd_choice),
    .upd_pdch_b     (upd_pdch_b),
    .upd_pdch_g     (upd_pdch_g),
    .upd_pdch_c     (upd_pdch_c),
    .clearing       (clearing)
  );

  // Advance one cycle; inputs change and outputs are sampled 1-2 ns after the edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic drive_ex(input logic v, input logic [2:0] k, input logic [3:0] gh,
                          input logic [3:0] bh, input logic tk);
    ex_valid        = v;
    kind_ex         = k;
    pc_ex           = {26'h0, gh};
    pc_ex_gh_hashed = gh;
    pc_ex_bh_hashed = bh;
    taken_real      = tk;
    choice_real     = ~tk;
    taken_pdch_ex_b = 2'b10;
    taken_pdch_ex_g = 2'b11;
    choice_pdch_ex  = 2'b00;
  endtask

  task automatic run_walk(input int first, input string tag);
    logic [3:0] e;
    for (int i = first; i < 16; i++) begin
      e = 4'(i);
      settle();
      n_total++;
      if ({upd_en, upd_clear, clearing, upd_gh_idx, upd_bh_idx, upd_pdch_b, upd_pdch_g,
           upd_pdch_c, upd_taken, upd_choice, pdc_grant, ex_ready} !==
          {3'b111, e, e, 6'b010101, 4'b0000})
        $display("FAIL %s idx %0d: en=%0b clr=%0b gh=%0h bh=%0h pb=%0b grant=%0b rdy=%0b want en=1 clr=1 gh=bh=%0h pdch=01 grant=0 rdy=0",
                 tag, i, upd_en, upd_clear, upd_gh_idx, upd_bh_idx, upd_pdch_b, pdc_grant,
                 ex_ready, e);
      else n_pass++;
      tick();
    end
    settle();
    n_total++;
    if ({clearing, ex_ready} !== 2'b01)
      $display("FAIL %s end: clearing=%0b ex_ready=%0b want 0 1", tag, clearing, ex_ready);
    else n_pass++;
  endtask

  task automatic test_reset;
    rst = 1'b1; flush_tables = 1'b0; pdc_req = 1'b1;
    drive_ex(1'b0, 3'd1, 4'h0, 4'h0, 1'b0);
    tick();
    settle();
    n_total++;
    if ({upd_en, upd_clear, clearing, ex_ready, pdc_grant, upd_gh_idx, upd_bh_idx} !==
        {5'b00100, 8'h00})
      $display("FAIL reset_outputs: en=%0b clr=%0b clearing=%0b rdy=%0b grant=%0b gh=%0h bh=%0h want 0 0 1 0 0 0 0",
               upd_en, upd_clear, clearing, ex_ready, pdc_grant, upd_gh_idx, upd_bh_idx);
    else n_pass++;
    tick();
    rst = 1'b0;
    run_walk(0, "reset_walk");
    pdc_req = 1'b0;
  endtask

  task automatic test_single_push;
    drive_ex(1'b1, 3'd1, 4'h5, 4'hA, 1'b1);
    settle();
    n_total++;
    if ({ex_ready, upd_en} !== 2'b10)
      $display("FAIL push_accept: ex_ready=%0b upd_en=%0b want 1 0", ex_ready, upd_en);
    else n_pass++;
    tick();
    drive_ex(1'b0, 3'd1, 4'h0, 4'h0, 1'b0);
    settle();
    n_total++;
    if ({upd_en, upd_clear, upd_gh_idx, upd_bh_idx, upd_taken, upd_choice, upd_pdch_b,
         upd_pdch_g, upd_pdch_c} !== {2'b10, 4'h5, 4'hA, 2'b10, 6'b101100})
      $display("FAIL push_write: en=%0b clr=%0b gh=%0h bh=%0h tk=%0b ch=%0b pb=%0b pg=%0b pc=%0b want 1 0 5 a 1 0 10 11 00",
               upd_en, upd_clear, upd_gh_idx, upd_bh_idx, upd_taken, upd_choice,
               upd_pdch_b, upd_pdch_g, upd_pdch_c);
    else n_pass++;
    tick();
    settle();
    n_total++;
    if (upd_en !== 1'b0) $display("FAIL push_drained: upd_en=%0b want 0", upd_en);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 4; i++) begin
      if (i < 3) drive_ex(1'b1, 3'd1, 4'(6 + i), 4'h3, 1'b0);
      else drive_ex(1'b0, 3'd1, 4'h0, 4'h0, 1'b0);
      settle();
      if (i > 0) begin
        n_total++;
        if ({upd_en, upd_gh_idx, ex_ready} !== {1'b1, 4'(5 + i), 1'b1})
          $display("FAIL b2b_%0d: en=%0b gh=%0h rdy=%0b want 1 %0h 1", i, upd_en,
                   upd_gh_idx, ex_ready, 4'(5 + i));
        else n_pass++;
      end
      tick();
    end
    settle();
    n_total++;
    if (upd_en !== 1'b0) $display("FAIL b2b_drained: upd_en=%0b want 0", upd_en);
    else n_pass++;
  endtask

  task automatic test_starvation;
    pdc_req = 1'b1;
    drive_ex(1'b1, 3'd1, 4'h9, 4'h1, 1'b1);
    settle();
    tick();
    drive_ex(1'b0, 3'd1, 4'h0, 4'h0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      settle();
      n_total++;
      if ({pdc_grant, upd_en} !== 2'b10)
        $display("FAIL starve_wait_%0d: grant=%0b en=%0b want 1 0", i, pdc_grant, upd_en);
      else n_pass++;
      tick();
    end
    settle();
    n_total++;
    if ({pdc_grant, upd_en, upd_gh_idx} !== {2'b01, 4'h9})
      $display("FAIL starve_force: grant=%0b en=%0b gh=%0h want 0 1 9", pdc_grant, upd_en,
               upd_gh_idx);
    else n_pass++;
    tick();
    settle();
    n_total++;
    if ({pdc_grant, upd_en} !== 2'b10)
      $display("FAIL starve_after: grant=%0b en=%0b want 1 0", pdc_grant, upd_en);
    else n_pass++;
    pdc_req = 1'b0;
  endtask

  task automatic test_full;
    pdc_req = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drive_ex(1'b1, 3'd1, 4'(i), 4'(i), 1'b0);
      settle();
      n_total++;
      if ({ex_ready, pdc_grant, upd_en} !== 3'b110)
        $display("FAIL full_push_%0d: rdy=%0b grant=%0b en=%0b want 1 1 0", i, ex_ready,
                 pdc_grant, upd_en);
      else n_pass++;
      tick();
    end
    drive_ex(1'b0, 3'd1, 4'h0, 4'h0, 1'b0);
    settle();
    n_total++;
    if ({ex_ready, upd_en, pdc_grant, upd_gh_idx} !== {3'b010, 4'h1})
      $display("FAIL full_force: rdy=%0b en=%0b grant=%0b gh=%0h want 0 1 0 1", ex_ready,
               upd_en, pdc_grant, upd_gh_idx);
    else n_pass++;
    tick();
    settle();
    n_total++;
    if ({ex_ready, upd_en, pdc_grant} !== 3'b101)
      $display("FAIL full_after: rdy=%0b en=%0b grant=%0b want 1 0 1", ex_ready, upd_en,
               pdc_grant);
    else n_pass++;
    pdc_req = 1'b0;
    for (int i = 2; i <= 4; i++) begin
      settle();
      n_total++;
      if ({upd_en, upd_gh_idx} !== {1'b1, 4'(i)})
        $display("FAIL full_drain_%0d: en=%0b gh=%0h want 1 %0h", i, upd_en, upd_gh_idx,
                 4'(i));
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_kinds;
    logic [2:0] kinds [3];
    kinds[0] = 3'd0; kinds[1] = 3'd2; kinds[2] = 3'd4;
    for (int i = 0; i < 3; i++) begin
      drive_ex(1'b1, kinds[i], 4'hE, 4'hE, 1'b1);
      settle();
      n_total++;
      if ({ex_ready, upd_en} !== 2'b10)
        $display("FAIL kind_%0d_accept: rdy=%0b en=%0b want 1 0", kinds[i], ex_ready, upd_en);
      else n_pass++;
      tick();
    end
    drive_ex(1'b0, 3'd1, 4'h0, 4'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      settle();
      n_total++;
      if (upd_en !== 1'b0) $display("FAIL kind_dropped_%0d: upd_en=%0b want 0", i, upd_en);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_flush;
    pdc_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_ex(1'b1, 3'd1, 4'(10 + i), 4'h2, 1'b1);
      tick();
    end
    drive_ex(1'b0, 3'd1, 4'h0, 4'h0, 1'b0);
    flush_tables = 1'b1;
    tick();
    flush_tables = 1'b0;
    pdc_req = 1'b0;
    run_walk(0, "flush_walk");
    for (int i = 0; i < 3; i++) begin
      settle();
      n_total++;
      if (upd_en !== 1'b0) $display("FAIL flush_no_old_%0d: upd_en=%0b want 0", i, upd_en);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_reset_mid_walk;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    settle();
    n_total++;
    if ({upd_en, upd_gh_idx} !== {1'b1, 4'h7})
      $display("FAIL midwalk_at7: en=%0b gh=%0h want 1 7", upd_en, upd_gh_idx);
    else n_pass++;
    rst = 1'b1;
    settle();
    n_total++;
    if ({upd_en, clearing} !== 2'b01)
      $display("FAIL midwalk_rst: en=%0b clearing=%0b want 0 1", upd_en, clearing);
    else n_pass++;
    tick();
    rst = 1'b0;
    run_walk(0, "midwalk_restart");
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_back_to_back();
    test_starvation();
    test_full();
    test_kinds();
    test_flush();
    test_reset_mid_walk();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
